alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Parametrised, multi-cycle multiply/divide unit for the RV32M extension.
- Sits beside the combinational `alu` in execute.
- Decode steers OP opcode instructions with funct7 = 0x01 here.
- Operands arrive with a valid/ready handshake; results leave with a valid/ready handshake.
- Iterative datapath: multiply retires MUL_BITS bits per cycle, divide retires 1 bit per cycle. Results are RISC-V compliant, including the divide-by-zero and overflow cases.

Parameters:
- DATA_WIDTH, 31, MSB index of operands/result (XLEN = DATA_WIDTH+1); XLEN must be even and ≥ 8.
- MUL_BITS, 2, multiplier bits consumed per cycle; legal values are 1, 2, 4; must divide XLEN.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  global enable; when low all state holds and no handshake completes.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request.
- i_funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_rs1_data  in  DATA_WIDTH+1  operand A (multiplicand / dividend).
- i_rs2_data  in  DATA_WIDTH+1  operand B (multiplier / divisor).
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_rd_data  out  DATA_WIDTH+1  result.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, o_valid=0, o_rd_data=0, o_busy=0, counters/accumulators=0.
- o_ready = (state==IDLE).
- Accept occurs when i_valid & o_ready & clk_en at a rising edge (cycle T). funct3 and operands are registered at accept; inputs are don't-care afterwards.
- States: IDLE, MUL, DIV, DONE.
- IDLE to DONE (fast path) on accept when either:
  - DIV/DIVU/REM/REMU with B==0, or
  - signed DIV/REM with A==most-negative and B==all-ones.
- IDLE to MUL on any other MUL*/ accept.
- IDLE to DIV on any other divide accept.
- MUL: runs XLEN/MUL_BITS iterations, one per enabled cycle, then goes to DONE.
- DIV: runs XLEN iterations of restoring division, then goes to DONE.
- DONE: o_valid=1. Moves to IDLE when i_ready & clk_en. o_valid, o_rd_data and state hold while i_ready is low.
- Latency, in enabled cycles from accept to o_valid high:
  - fast path: 1
  - multiply: XLEN/MUL_BITS + 1
  - divide: XLEN + 1
- Sign and result fix-up are applied in the final iteration cycle, with no extra cycle.
- The clk_en-low cycles add exactly their own count to latency.
- No back-to-back acceptance. The next accept is possible in the cycle after the DONE handshake, i.e. when IDLE is re-entered.
- Arithmetic:
  - Signed operands are converted to magnitudes. The product is 2*XLEN bits.
  - MUL returns the low XLEN bits.
  - MULH returns the high half, signed×signed.
  - MULHSU returns the high half, A signed × B unsigned.
  - MULHU returns the high half, unsigned×unsigned.
  - Product sign = sign(A) xor sign(B), counting only the operands treated as signed.
  - DIV/DIVU: quotient truncates toward zero. REM/REMU: remainder takes the sign of the dividend.
- Special results:
  - B==0: DIV/DIVU return all-ones; REM/REMU return A.
  - Signed overflow: DIV returns A (most-negative); REM returns 0.
- o_rd_data is registered, updated only on entry to DONE, and holds its last value in IDLE.
- Reset mid-operation aborts the operation: no result is produced, and o_valid is 0 from reset assertion onward.
- Unknown funct3 is impossible (all 8 codes are defined).

Test Plan:
- MUL, A=7, B=0xFFFFFFFD (-3) -> o_rd_data=0xFFFFFFEB; o_valid exactly 17 cycles after accept (MUL_BITS=2); o_ready low throughout.
- MULH A=B=0x80000000 -> 0x40000000; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU A=B=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD, latency 33; REM same operands -> 0xFFFFFFFF; DIVU A=100, B=7 -> 14; REMU A=100, B=7 -> 2.
- DIVU A=5, B=0 -> 0xFFFFFFFF; REM A=5, B=0 -> 5; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0. All four with latency 1.
- Backpressure and stall:
  - Hold i_ready low 3 cycles in DONE -> o_valid and o_rd_data stable and o_ready low for those cycles; IDLE the cycle after the handshake.
  - Drop clk_en for 4 cycles mid-divide -> latency 37.
- Assert rst at iteration 10 of a DIV -> o_valid=0 and o_ready=1 after reset release. A new MUL 3×5 accepted next returns 15 with no stale result.

Source files
------------

// File: rtl/alu_mdu_if.sv
// Request/response bundle for the RV32M multiply/divide unit: operands in
// with a valid/ready handshake, result out with a valid/ready handshake.
interface alu_mdu_if #(
    parameter int DATA_WIDTH = 31
);
    logic                  i_valid;
    logic                  o_ready;
    logic [2:0]            i_funct3;
    logic [DATA_WIDTH:0]   i_rs1_data;
    logic [DATA_WIDTH:0]   i_rs2_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH:0]   o_rd_data;
    logic                  o_busy;

    modport master (
        output i_valid, i_funct3, i_rs1_data, i_rs2_data, i_ready,
        input  o_ready, o_valid, o_rd_data, o_busy
    );

    modport slave (
        input  i_valid, i_funct3, i_rs1_data, i_rs2_data, i_ready,
        output o_ready, o_valid, o_rd_data, o_busy
    );
endinterface

// File: rtl/alu_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply retiring MUL_BITS
// multiplier bits per cycle, restoring divide retiring one quotient bit per cycle.
module alu_mdu #(
    parameter int DATA_WIDTH = 31,
    parameter int MUL_BITS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    alu_mdu_if.slave   bus
);
    localparam int XLEN      = DATA_WIDTH + 1;
    localparam int MUL_ITERS = XLEN / MUL_BITS;
    localparam int CW        = $clog2(XLEN);

    localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_ITERS - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic              res_neg;
    logic              sel_hi;
    logic [XLEN-1:0]   rd_data;

    logic              is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic              b_zero, ovf, fast;
    logic [XLEN-1:0]   a_abs, b_abs, fast_res;

    logic [XLEN+MUL_BITS-1:0]   partial, mul_hi;
    logic [2*XLEN+MUL_BITS-1:0] mul_wide;
    logic [2*XLEN-1:0]          mul_next, mul_sgn;
    logic [XLEN-1:0]            mul_res;

    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   div_sel, div_res;

    // Request decode: operand signedness, magnitudes and the special divide cases
    always_comb begin
        is_div   = bus.i_funct3[2];
        a_sgn    = is_div ? ~bus.i_funct3[0] : (bus.i_funct3[1:0] != 2'b11);
        b_sgn    = is_div ? ~bus.i_funct3[0] : ~bus.i_funct3[1];
        a_neg    = a_sgn & bus.i_rs1_data[XLEN-1];
        b_neg    = b_sgn & bus.i_rs2_data[XLEN-1];
        a_abs    = a_neg ? -bus.i_rs1_data : bus.i_rs1_data;
        b_abs    = b_neg ? -bus.i_rs2_data : bus.i_rs2_data;
        b_zero   = (bus.i_rs2_data == '0);
        ovf      = is_div & ~bus.i_funct3[0] & (bus.i_rs1_data == MOST_NEG)
                   & (bus.i_rs2_data == '1);
        fast     = is_div & (b_zero | ovf);
        fast_res = '0;
        if (b_zero)
            fast_res = bus.i_funct3[1] ? bus.i_rs1_data : '1;
        else
            fast_res = bus.i_funct3[1] ? '0 : bus.i_rs1_data;
    end

    // acc holds {partial product, remaining multiplier bits}; both shift right together
    always_comb begin
        partial  = {{MUL_BITS{1'b0}}, opnd} * {{XLEN{1'b0}}, acc[MUL_BITS-1:0]};
        mul_hi   = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]} + partial;
        mul_wide = {mul_hi, acc[XLEN-1:0]};
        mul_next = mul_wide[2*XLEN+MUL_BITS-1:MUL_BITS];
        mul_sgn  = res_neg ? -mul_next : mul_next;
        mul_res  = sel_hi ? mul_sgn[2*XLEN-1:XLEN] : mul_sgn[XLEN-1:0];
    end

    // acc holds {partial remainder, dividend/quotient}; quotient bits enter at the LSB
    always_comb begin
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opnd};
        div_ok    = ~div_diff[XLEN];
        div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                     acc[XLEN-2:0], div_ok};
        div_sel   = sel_hi ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
        div_res   = res_neg ? -div_sel : div_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            opnd    <= '0;
            acc     <= '0;
            res_neg <= 1'b0;
            sel_hi  <= 1'b0;
            rd_data <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        count <= '0;
                        if (fast) begin
                            state   <= DONE;
                            rd_data <= fast_res;
                        end else if (is_div) begin
                            state   <= DIV;
                            opnd    <= b_abs;
                            acc     <= {{XLEN{1'b0}}, a_abs};
                            res_neg <= bus.i_funct3[1] ? a_neg : (a_neg ^ b_neg);
                            sel_hi  <= bus.i_funct3[1];
                        end else begin
                            state   <= MUL;
                            opnd    <= a_abs;
                            acc     <= {{XLEN{1'b0}}, b_abs};
                            res_neg <= a_neg ^ b_neg;
                            sel_hi  <= (bus.i_funct3[1:0] != 2'b00);
                        end
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count + 1'b1;
                    if (count == MUL_LAST) begin
                        state   <= DONE;
                        rd_data <= mul_res;
                    end
                end
                DIV: begin
                    acc   <= div_next;
                    count <= count + 1'b1;
                    if (count == DIV_LAST) begin
                        state   <= DONE;
                        rd_data <= div_res;
                    end
                end
                DONE: begin
                    if (bus.i_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready   = (state == IDLE);
    assign bus.o_valid   = (state == DONE);
    assign bus.o_busy    = (state != IDLE);
    assign bus.o_rd_data = rd_data;
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed RV32M cases, handshake/stall/reset
// scenarios, then random operations checked against a plain-arithmetic model.
module tb_alu_mdu;
    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_mdu_if #(.DATA_WIDTH(31)) bus ();

    alu_mdu #(.DATA_WIDTH(31), .MUL_BITS(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        int signed   ia, ib;
        sa = {{32{a[31]}}, a};
        ua = {32'h0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'h0, b};
        ia = a;
        ib = b;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f3[2]) return 32 / 2 + 1;
        if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 32 + 1;
    endfunction

    // Issue one request, count edges to o_valid, optionally stall/backpressure, handshake out
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_d, input int exp_lat,
                         input int hold, input int stall_at);
        int   lat;
        int   guard;
        logic rdy_leak;
        guard = 0;
        while (bus.o_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_ready_before"}, 64'(bus.o_ready), 64'd1);
        bus.i_valid    = 1'b1;
        bus.i_funct3   = f3;
        bus.i_rs1_data = a;
        bus.i_rs2_data = b;
        bus.i_ready    = 1'b0;
        @(posedge clk); #1;
        bus.i_valid    = 1'b0;
        bus.i_funct3   = 3'($urandom);
        bus.i_rs1_data = $urandom;
        bus.i_rs2_data = $urandom;
        lat      = 1;
        rdy_leak = 1'b0;
        while (bus.o_valid !== 1'b1 && lat < 300) begin
            if (bus.o_ready !== 1'b0) rdy_leak = 1'b1;
            if (stall_at > 0 && lat == stall_at)     clk_en = 1'b0;
            if (stall_at > 0 && lat == stall_at + 4) clk_en = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        clk_en = 1'b1;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, 64'(bus.o_rd_data), 64'(exp_d));
        check({tag, "_ready_low_while_busy"}, 64'(rdy_leak), 64'd0);
        check({tag, "_busy"}, 64'(bus.o_busy), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 64'(bus.o_valid), 64'd1);
            check({tag, "_hold_data"}, 64'(bus.o_rd_data), 64'(exp_d));
            check({tag, "_hold_ready"}, 64'(bus.o_ready), 64'd0);
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        check({tag, "_idle_after"}, {62'd0, bus.o_valid, bus.o_ready}, 64'd1);
        check({tag, "_data_kept"}, 64'(bus.o_rd_data), 64'(exp_d));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          lat;

        rst            = 1'b1;
        clk_en         = 1'b1;
        bus.i_valid    = 1'b0;
        bus.i_ready    = 1'b0;
        bus.i_funct3   = 3'd0;
        bus.i_rs1_data = 32'h0;
        bus.i_rs2_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 64'(bus.o_valid), 64'd0);
        check("reset_busy", 64'(bus.o_busy), 64'd0);
        check("reset_ready", 64'(bus.o_ready), 64'd1);
        check("reset_data", 64'(bus.o_rd_data), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 17, 0, 0);
        do_op("mulh_minmin", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 17, 0, 0);
        do_op("mulhu_ones",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 17, 0, 0);
        do_op("mulhsu_ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17, 0, 0);
        do_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0, 0);
        do_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0, 0);
        do_op("divu_100_7",  3'd5, 32'd100,       32'd7,         32'd14,        33, 0, 0);
        do_op("remu_100_7",  3'd7, 32'd100,       32'd7,         32'd2,         33, 0, 0);
        do_op("divu_by0",    3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF,  1, 0, 0);
        do_op("rem_by0",     3'd6, 32'd5,         32'd0,         32'd5,          1, 0, 0);
        do_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  1, 0, 0);
        do_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1, 0, 0);
        do_op("backpressure", 3'd0, 32'h1234_5678, 32'h10,       32'h2345_6780, 17, 3, 0);
        do_op("stall_divu",  3'd5, 32'd100,       32'd7,         32'd14,        37, 0, 10);

        // Abort a divide partway through with an asynchronous reset
        bus.i_valid    = 1'b1;
        bus.i_funct3   = 3'd5;
        bus.i_rs1_data = 32'd1000;
        bus.i_rs2_data = 32'd3;
        bus.i_ready    = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("abort_busy_before", 64'(bus.o_busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_valid_in_reset", 64'(bus.o_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_ready_after", 64'(bus.o_ready), 64'd1);
        check("abort_valid_after", 64'(bus.o_valid), 64'd0);
        check("abort_data_cleared", 64'(bus.o_rd_data), 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.o_valid !== 1'b0) break;
        end
        check("abort_no_stale_result", 64'(bus.o_valid), 64'd0);
        bus.i_ready = 1'b0;
        do_op("mul_after_abort", 3'd0, 32'd3, 32'd5, 32'd15, 17, 0, 0);

        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            do_op($sformatf("rand%0d_f%0d", n, f3), f3, a, b, ref_mdu(f3, a, b),
                  ref_lat(f3, a, b), $urandom_range(0, 2), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
